// File: rtl/alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Brief    : Sequential ALU, 16 ops, iterative multiply and shift, valid/ready.
//             Optional flag outputs enabled by defining ALU_FLAGS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    output logic             o_valid,
`ifdef ALU_FLAGS_EN
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_neg,
`endif
    output logic [WIDTH-1:0] o_data
);

    localparam int SHW      = $clog2(WIDTH);
    localparam int c_cnt_w  = $clog2(WIDTH + 1);

    localparam logic [3:0] c_op_nop = 4'h0, c_op_add = 4'h1, c_op_sub = 4'h2, c_op_mul  = 4'h3,
                           c_op_and = 4'h4, c_op_or  = 4'h5, c_op_xor = 4'h6, c_op_not  = 4'h7,
                           c_op_rol = 4'h8, c_op_ror = 4'h9, c_op_lsl = 4'hA, c_op_lsr  = 4'hB,
                           c_op_asr = 4'hC, c_op_mulh = 4'hD, c_op_eq = 4'hE, c_op_lt   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [SHW-1:0]         r_n;
    logic [3:0]             r_op;
    logic [WIDTH-1:0]       r_data;
    logic                   r_valid;

    logic [SHW-1:0]         w_n;
    logic                   w_is_mul;
    logic                   w_is_shift;
    logic [WIDTH-1:0]       w_res;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]       w_mul_res;
    logic [WIDTH-1:0]       w_sh_next;

    assign w_n        = i_arg1[SHW-1:0];
    assign w_is_mul   = (i_op == c_op_mul) || (i_op == c_op_mulh);
    assign w_is_shift = (i_op >= c_op_rol) && (i_op <= c_op_asr);

    // Single-cycle result; shift ops only reach this path with n == 0.
    always_comb begin
        w_res = i_arg0;
        case (i_op)
            c_op_add: w_res = i_arg0 + i_arg1;
            c_op_sub: w_res = i_arg0 - i_arg1;
            c_op_and: w_res = i_arg0 & i_arg1;
            c_op_or:  w_res = i_arg0 | i_arg1;
            c_op_xor: w_res = i_arg0 ^ i_arg1;
            c_op_not: w_res = ~i_arg0;
            c_op_eq:  w_res = (i_arg0 == i_arg1) ? '1 : '0;
            c_op_lt:  w_res = ($signed(i_arg0) < $signed(i_arg1)) ? '1 : '0;
            default:  w_res = i_arg0;
        endcase
    end

    // Shift-add multiply: add into the high half, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_mul_res  = (r_op == c_op_mulh) ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];

    always_comb begin
        w_sh_next = r_a;
        case (r_op)
            c_op_rol: w_sh_next = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
            c_op_ror: w_sh_next = {r_a[0], r_a[WIDTH-1:1]};
            c_op_lsl: w_sh_next = {r_a[WIDTH-2:0], 1'b0};
            c_op_lsr: w_sh_next = {1'b0, r_a[WIDTH-1:1]};
            c_op_asr: w_sh_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            default:  w_sh_next = r_a;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic             r_zero;
    logic             r_carry;
    logic             r_neg;
    logic             w_cy;
    logic             w_sh_out;
    logic [WIDTH:0]   w_add_full;

    assign w_add_full = {1'b0, i_arg0} + {1'b0, i_arg1};
    assign w_cy       = (i_op == c_op_add) ? w_add_full[WIDTH] :
                        (i_op == c_op_sub) ? (i_arg0 < i_arg1) : 1'b0;
    assign w_sh_out   = (r_op == c_op_rol || r_op == c_op_lsl) ? r_a[WIDTH-1] : r_a[0];

    assign o_zero  = r_zero;
    assign o_carry = r_carry;
    assign o_neg   = r_neg;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_n     <= '0;
            r_op    <= c_op_nop;
            r_data  <= '0;
            r_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_neg   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (w_is_mul) begin
                            r_a     <= i_arg0;
                            r_b     <= i_arg1;
                            r_acc   <= '0;
                            r_cnt   <= c_cnt_w'(WIDTH);
                            r_op    <= i_op;
                            r_state <= S_MUL;
                        end else if (w_is_shift && (w_n != '0)) begin
                            r_a     <= i_arg0;
                            r_n     <= w_n;
                            r_op    <= i_op;
                            r_state <= S_SHIFT;
                        end else begin
                            r_data  <= w_res;
                            r_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                            r_zero  <= (w_res == '0);
                            r_neg   <= w_res[WIDTH-1];
                            r_carry <= w_cy;
`endif
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_data  <= w_mul_res;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
`ifdef ALU_FLAGS_EN
                        r_zero  <= (w_mul_res == '0);
                        r_neg   <= w_mul_res[WIDTH-1];
                        r_carry <= (r_op == c_op_mul) && (w_acc_next[2*WIDTH-1:WIDTH] != '0);
`endif
                    end
                end
                S_SHIFT: begin
                    r_a <= w_sh_next;
                    r_n <= r_n - SHW'(1);
                    if (r_n == SHW'(1)) begin
                        r_data  <= w_sh_next;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
`ifdef ALU_FLAGS_EN
                        r_zero  <= (w_sh_next == '0);
                        r_neg   <= w_sh_next[WIDTH-1];
                        r_carry <= w_sh_out;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Brief    : Directed and randomized self-checking bench for alu_seq (WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_op;
    logic [7:0] i_arg0;
    logic [7:0] i_arg1;
    logic       o_valid;
    logic [7:0] o_data;
`ifdef ALU_FLAGS_EN
    logic       o_zero;
    logic       o_carry;
    logic       o_neg;
`endif

    int n_chk = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(8)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_arg0  (i_arg0),
        .i_arg1  (i_arg1),
        .o_valid (o_valid),
`ifdef ALU_FLAGS_EN
        .o_zero  (o_zero),
        .o_carry (o_carry),
        .o_neg   (o_neg),
`endif
        .o_data  (o_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from the opcode table using plain integer arithmetic.
    function automatic logic [7:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai = a;
        int bi = b;
        int n  = b % 8;
        int p  = ai * bi;
        int r;
        logic signed [7:0] sa = a;
        logic signed [7:0] sb = b;
        case (op)
            4'h0: r = ai;
            4'h1: r = ai + bi;
            4'h2: r = ai - bi;
            4'h3: r = p;
            4'h4: r = ai & bi;
            4'h5: r = ai | bi;
            4'h6: r = ai ^ bi;
            4'h7: r = ~ai;
            4'h8: r = (ai << n) | (ai >> (8 - n));
            4'h9: r = (ai >> n) | (ai << (8 - n));
            4'hA: r = ai << n;
            4'hB: r = ai >> n;
            4'hC: r = int'(sa) >>> n;
            4'hD: r = p / 256;
            4'hE: r = (ai == bi) ? 255 : 0;
            default: r = (int'(sa) < int'(sb)) ? 255 : 0;
        endcase
        return r[7:0];
    endfunction

    // Edges after the accept edge until the result edge.
    function automatic int latency(input logic [3:0] op, input logic [7:0] b);
        if (op == 4'h3 || op == 4'hD) return 8;
        if (op >= 4'h8 && op <= 4'hC) return b % 8;
        return 0;
    endfunction

    // Called at a negedge while idle; returns at the negedge after the o_valid cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prev;
        logic [7:0] exp_d;
        int         exp_lat;
        int         lat;
        logic       busy_ok;
        exp_d   = model(op, a, b);
        exp_lat = latency(op, b);
        prev    = o_data;
        busy_ok = 1'b1;
        i_op = op; i_arg0 = a; i_arg1 = b; i_valid = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_valid = 1'b0;
        i_op = 4'($urandom); i_arg0 = 8'($urandom); i_arg1 = 8'($urandom);
        lat = 0;
        while (!o_valid && lat < 40) begin
            if (o_ready !== 1'b0 || o_data !== prev) busy_ok = 1'b0;
            @(posedge i_clk); @(negedge i_clk);
            lat++;
        end
        chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, 32'(o_data), 32'(exp_d));
        @(posedge i_clk); @(negedge i_clk);
        chk({tag, "_pulse"}, {30'd0, o_valid, o_ready}, 32'b01);
    endtask

    initial begin
        logic [7:0] hold;
        int         pulses;
        i_rst = 1'b1; i_valid = 1'b0; i_op = 4'h0; i_arg0 = 8'h00; i_arg1 = 8'h00;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data",  32'(o_data),  32'h00);

        // Back-to-back single-cycle ops
        i_op = 4'h1; i_arg0 = 8'hF0; i_arg1 = 8'h20; i_valid = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        chk("add_valid", {30'd0, o_valid, o_ready}, 32'b11);
        chk("add_data", 32'(o_data), 32'h10);
`ifdef ALU_FLAGS_EN
        chk("add_carry", 32'(o_carry), 32'd1);
`endif
        i_op = 4'h2; i_arg0 = 8'h05; i_arg1 = 8'h07;
        @(posedge i_clk); @(negedge i_clk);
        chk("sub_valid", {30'd0, o_valid, o_ready}, 32'b11);
        chk("sub_data", 32'(o_data), 32'hFE);
`ifdef ALU_FLAGS_EN
        chk("sub_flags", {30'd0, o_carry, o_neg}, 32'b11);
`endif
        i_valid = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
        chk("sub_after", 32'(o_valid), 32'd0);

        run_op("mul",  4'h3, 8'h0D, 8'h0B);
        chk("mul_const", 32'(o_data), 32'h8F);
        run_op("mulh", 4'hD, 8'hFF, 8'hFF);
        chk("mulh_const", 32'(o_data), 32'hFE);
        run_op("rol",  4'h8, 8'h81, 8'h01);
        chk("rol_const", 32'(o_data), 32'h03);
        run_op("asr",  4'hC, 8'h80, 8'h07);
        chk("asr_const", 32'(o_data), 32'hFF);
        run_op("lsr0", 4'hB, 8'hAA, 8'h00);
        run_op("eq",   4'hE, 8'h3C, 8'h3C);
        run_op("lt_a", 4'hF, 8'h80, 8'h01);
        chk("lt_a_const", 32'(o_data), 32'hFF);
        run_op("lt_b", 4'hF, 8'h01, 8'h80);
        chk("lt_b_const", 32'(o_data), 32'h00);

        // Requests while busy are dropped
        i_op = 4'h3; i_arg0 = 8'h0D; i_arg1 = 8'h0B; i_valid = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        hold = o_data;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            i_valid = (c == 1 || c == 4) ? 1'b1 : 1'b0;
            i_op = 4'hD; i_arg0 = 8'hFF; i_arg1 = 8'hFF;
            if (o_valid) begin
                pulses++;
                hold = o_data;
            end else if (o_data !== hold) begin
                pulses += 100;
            end
            @(posedge i_clk); @(negedge i_clk);
        end
        i_valid = 1'b0;
        chk("busy_pulses", 32'(pulses), 32'd1);
        chk("busy_data", 32'(o_data), 32'h8F);

        // Reset abandons a multiply in flight
        i_op = 4'h3; i_arg0 = 8'h12; i_arg1 = 8'h34; i_valid = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_rst = 1'b0;
        chk("midrst_state", {30'd0, o_ready, o_valid}, 32'b10);
        chk("midrst_data", 32'(o_data), 32'h00);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (o_valid) pulses++;
            @(posedge i_clk); @(negedge i_clk);
        end
        chk("midrst_novalid", 32'(pulses), 32'd0);

        for (int k = 0; k < 40; k++) begin
            run_op("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
